// File: rtl/dsp_mac_pkg.sv
// rtl/dsp_mac_pkg.sv - shared op-bit indices and arithmetic helpers for the MAC slice
package dsp_mac_pkg;

    localparam int OP_PRE     = 0;
    localparam int OP_PRESUB  = 1;
    localparam int OP_POSTSUB = 2;

    // Working width for the helpers; comfortably wider than any PW+1 sum
    localparam int XW = 128;
    typedef logic signed [XW-1:0] wide_t;

    // Clamp a sign-extended value into the signed range of 'width' bits
    function automatic wide_t sat(input wide_t value, input int width);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

    // Keep the low 'width' bits and sign-extend them (two's-complement wrap)
    function automatic wide_t wrap(input wide_t value, input int width);
        wide_t t;
        t = value <<< (XW - width);
        return t >>> (XW - width);
    endfunction

    // Arithmetic right shift with round-half-up
    function automatic wide_t round_shift(input wide_t value, input int shift);
        wide_t v;
        v = value;
        if (shift > 0) v = v + (wide_t'(1) <<< (shift - 1));
        return v >>> shift;
    endfunction

endpackage

// File: rtl/dsp_mac_acc_bank.sv
// rtl/dsp_mac_acc_bank.sv - per-channel accumulator registers with sticky overflow flags
module dsp_mac_acc_bank
    import dsp_mac_pkg::*;
#(
    parameter int PW  = 48,
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en_i,
    input  logic           clr_i,
    input  logic [CHW-1:0] rd_ch_i,
    output logic [PW-1:0]  rd_data_o,
    input  logic           wr_en_i,
    input  logic [CHW-1:0] wr_ch_i,
    input  logic [PW-1:0]  wr_data_i,
    input  logic           wr_ovf_i,
    output logic [NCH-1:0] sticky_o
);

    logic [PW-1:0]  acc_q [NCH];
    logic [NCH-1:0] sticky_q;

    // Combinational read; a channel tag beyond NCH reads as zero
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NCH; i++) begin
            if (CHW'(i) == rd_ch_i) rd_data_o = acc_q[i];
        end
    end

    // Clear beats a same-cycle write; out-of-range tags match no entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
            sticky_q <= '0;
        end else if (en_i) begin
            if (clr_i) begin
                for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
                sticky_q <= '0;
            end else if (wr_en_i) begin
                for (int i = 0; i < NCH; i++) begin
                    if (CHW'(i) == wr_ch_i) begin
                        acc_q[i] <= wr_data_i;
                        if (wr_ovf_i) sticky_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign sticky_o = sticky_q;

endmodule

// File: rtl/dsp_mac_slice.sv
// rtl/dsp_mac_slice.sv - pipelined signed pre-add/multiply/accumulate slice with channel bank
module dsp_mac_slice
    import dsp_mac_pkg::*;
#(
    parameter int AW     = 18,
    parameter int BW     = 18,
    parameter int DW     = 18,
    parameter int PW     = 48,
    parameter int NCH    = 4,
    parameter int SAT    = 1,
    parameter int OSHIFT = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic                                   clr_acc,
    input  logic                                   in_valid,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] in_ch,
    input  logic                                   in_load,
    input  logic [2:0]                             in_op,
    input  logic [AW-1:0]                          a,
    input  logic [BW-1:0]                          b,
    input  logic [DW-1:0]                          d,
    input  logic [PW-1:0]                          c,
    output logic                                   out_valid,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch,
    output logic [PW-1:0]                          out_p,
    output logic                                   out_ovf,
    output logic [NCH-1:0]                         ovf_sticky
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int MW  = ((BW > DW) ? BW : DW) + 1;

    // S1: registered inputs
    logic           s1_valid_q, s1_load_q;
    logic [CHW-1:0] s1_ch_q;
    logic [2:0]     s1_op_q;
    logic [AW-1:0]  s1_a_q;
    logic [BW-1:0]  s1_b_q;
    logic [DW-1:0]  s1_d_q;
    logic [PW-1:0]  s1_c_q;

    // S2: registered product plus tags
    logic           s2_valid_q, s2_load_q, s2_postsub_q;
    logic [CHW-1:0] s2_ch_q;
    logic [PW-1:0]  s2_c_q;
    logic [PW-1:0]  s2_prod_q;

    // S3: registered accumulator result awaiting output scaling
    logic                 s3_valid_q, s3_ovf_q;
    logic [CHW-1:0]       s3_ch_q;
    logic signed [PW-1:0] s3_acc_q;

    // Output registers
    logic           out_valid_q, out_ovf_q;
    logic [CHW-1:0] out_ch_q;
    logic [PW-1:0]  out_p_q;

    logic signed [MW-1:0] b_e, d_e, pre;
    logic signed [PW-1:0] a_w, pre_w, prod_d;
    logic [PW-1:0]        rd_data, base;
    logic signed [PW:0]   sum;
    logic                 s3_ovf;
    logic [PW-1:0]        acc_new;
    logic [PW-1:0]        out_p_d;

    // S1 capture of the incoming sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_load_q  <= 1'b0;
            s1_ch_q    <= '0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_d_q     <= '0;
            s1_c_q     <= '0;
        end else if (en) begin
            s1_valid_q <= in_valid;
            s1_load_q  <= in_load;
            s1_ch_q    <= in_ch;
            s1_op_q    <= in_op;
            s1_a_q     <= a;
            s1_b_q     <= b;
            s1_d_q     <= d;
            s1_c_q     <= c;
        end
    end

    // Pre-adder at one bit above the wider operand, then full-precision product
    always_comb begin
        b_e    = {{(MW - BW){s1_b_q[BW-1]}}, s1_b_q};
        d_e    = {{(MW - DW){s1_d_q[DW-1]}}, s1_d_q};
        pre    = s1_op_q[OP_PRE] ? (s1_op_q[OP_PRESUB] ? d_e - b_e : d_e + b_e) : b_e;
        a_w    = {{(PW - AW){s1_a_q[AW-1]}}, s1_a_q};
        pre_w  = {{(PW - MW){pre[MW-1]}}, pre};
        prod_d = a_w * pre_w;
    end

    // S2 capture of the product; only the post-adder op bit is still needed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q   <= 1'b0;
            s2_load_q    <= 1'b0;
            s2_postsub_q <= 1'b0;
            s2_ch_q      <= '0;
            s2_c_q       <= '0;
            s2_prod_q    <= '0;
        end else if (en) begin
            s2_valid_q   <= s1_valid_q;
            s2_load_q    <= s1_load_q;
            s2_postsub_q <= s1_op_q[OP_POSTSUB];
            s2_ch_q      <= s1_ch_q;
            s2_c_q       <= s1_c_q;
            s2_prod_q    <= prod_d;
        end
    end

    // Read and write of the bank both happen here, so back-to-back samples see each other
    always_comb begin
        base    = s2_load_q ? s2_c_q : rd_data;
        sum     = s2_postsub_q ? ({base[PW-1], base} - {s2_prod_q[PW-1], s2_prod_q})
                               : ({base[PW-1], base} + {s2_prod_q[PW-1], s2_prod_q});
        s3_ovf  = sum[PW] ^ sum[PW-1];
        acc_new = (SAT != 0) ? PW'(sat(wide_t'(sum), PW)) : PW'(wrap(wide_t'(sum), PW));
    end

    dsp_mac_acc_bank #(
        .PW  (PW),
        .NCH (NCH),
        .CHW (CHW)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en),
        .clr_i     (clr_acc),
        .rd_ch_i   (s2_ch_q),
        .rd_data_o (rd_data),
        .wr_en_i   (s2_valid_q),
        .wr_ch_i   (s2_ch_q),
        .wr_data_i (acc_new),
        .wr_ovf_i  (s3_ovf),
        .sticky_o  (ovf_sticky)
    );

    // S3 capture of the unscaled result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid_q <= 1'b0;
            s3_ovf_q   <= 1'b0;
            s3_ch_q    <= '0;
            s3_acc_q   <= '0;
        end else if (en) begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_ovf_q <= s3_ovf;
                s3_ch_q  <= s2_ch_q;
                s3_acc_q <= acc_new;
            end
        end
    end

    // Output scaling only; the stored accumulator stays unscaled
    always_comb begin
        out_p_d = (SAT != 0) ? PW'(sat(round_shift(wide_t'(s3_acc_q), OSHIFT), PW))
                             : PW'(wrap(round_shift(wide_t'(s3_acc_q), OSHIFT), PW));
    end

    // Output register; data fields hold between valid results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_ch_q    <= '0;
            out_p_q     <= '0;
        end else if (en) begin
            out_valid_q <= s3_valid_q;
            if (s3_valid_q) begin
                out_ovf_q <= s3_ovf_q;
                out_ch_q  <= s3_ch_q;
                out_p_q   <= out_p_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_p     = out_p_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dsp_mac_slice.sv
// tb/tb_dsp_mac_slice.sv - scoreboard bench for saturating, wrapping and scaled slice variants
module tb_dsp_mac_slice;

    localparam longint MAXV = 64'sh0000_7FFF_FFFF_FFFF;
    localparam longint MINV = -MAXV - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        clr_acc = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_ch = '0;
    logic        in_load = 1'b0;
    logic [2:0]  in_op = '0;
    logic [17:0] a = '0, b = '0, d = '0;
    logic [47:0] c = '0;

    logic        s_valid, w_valid, r_valid;
    logic [1:0]  s_ch, w_ch, r_ch;
    logic [47:0] s_p, w_p, r_p;
    logic        s_ovf, w_ovf, r_ovf;
    logic [3:0]  s_stk, w_stk;
    logic [2:0]  r_stk;

    dsp_mac_slice #(.SAT(1), .OSHIFT(0), .NCH(4)) dut_s (
        .clk(clk), .rst(rst), .en(en), .clr_acc(clr_acc), .in_valid(in_valid), .in_ch(in_ch),
        .in_load(in_load), .in_op(in_op), .a(a), .b(b), .d(d), .c(c),
        .out_valid(s_valid), .out_ch(s_ch), .out_p(s_p), .out_ovf(s_ovf), .ovf_sticky(s_stk));

    dsp_mac_slice #(.SAT(0), .OSHIFT(0), .NCH(4)) dut_w (
        .clk(clk), .rst(rst), .en(en), .clr_acc(clr_acc), .in_valid(in_valid), .in_ch(in_ch),
        .in_load(in_load), .in_op(in_op), .a(a), .b(b), .d(d), .c(c),
        .out_valid(w_valid), .out_ch(w_ch), .out_p(w_p), .out_ovf(w_ovf), .ovf_sticky(w_stk));

    dsp_mac_slice #(.SAT(1), .OSHIFT(2), .NCH(3)) dut_r (
        .clk(clk), .rst(rst), .en(en), .clr_acc(clr_acc), .in_valid(in_valid), .in_ch(in_ch),
        .in_load(in_load), .in_op(in_op), .a(a), .b(b), .d(d), .c(c),
        .out_valid(r_valid), .out_ch(r_ch), .out_p(r_p), .out_ovf(r_ovf), .ovf_sticky(r_stk));

    always #5 clk = ~clk;

    typedef struct {
        int     ch;
        int     due;
        longint p_s, p_w, p_r;
        bit     ovf_s, ovf_w, ovf_r;
    } exp_t;

    exp_t   sb[$];
    longint acc_s[4], acc_w[4], acc_r[3];
    logic [3:0] stk_s, stk_w;
    logic [2:0] stk_r;
    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint clamp48(input longint x);
        if (x > MAXV) return MAXV;
        if (x < MINV) return MINV;
        return x;
    endfunction

    function automatic longint wrap48(input longint x);
        logic [47:0] t;
        t = x[47:0];
        return longint'($signed(t));
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) begin acc_s[i] = 0; acc_w[i] = 0; end
        for (int i = 0; i < 3; i++) acc_r[i] = 0;
        stk_s = '0; stk_w = '0; stk_r = '0;
    endfunction

    task automatic check_out();
        exp_t e;
        bit   exp_v;
        exp_v = (sb.size() > 0) && (sb[0].due == edge_cnt);
        chk("valid_s", s_valid, exp_v);
        chk("valid_w", w_valid, exp_v);
        chk("valid_r", r_valid, exp_v);
        if (exp_v) begin
            e = sb.pop_front();
            chk("ch_s", s_ch, e.ch);
            chk("p_s", $signed(s_p), e.p_s);
            chk("ovf_s", s_ovf, e.ovf_s);
            chk("p_w", $signed(w_p), e.p_w);
            chk("ovf_w", w_ovf, e.ovf_w);
            chk("ch_r", r_ch, e.ch);
            chk("p_r", $signed(r_p), e.p_r);
            chk("ovf_r", r_ovf, e.ovf_r);
        end
    endtask

    task automatic step();
        bit e;
        @(posedge clk);
        e = en;
        #1;
        if (e) begin
            edge_cnt++;
            check_out();
        end
    endtask

    task automatic send(input int ch, input bit ld, input logic [2:0] op,
                        input longint av, input longint bv, input longint dv, input longint cv);
        exp_t   e;
        longint pre, prod, base, sum, nv;
        in_valid = 1'b1; in_ch = 2'(ch); in_load = ld; in_op = op;
        a = 18'(av); b = 18'(bv); d = 18'(dv); c = 48'(cv);
        pre  = op[0] ? (op[1] ? dv - bv : dv + bv) : bv;
        prod = av * pre;
        e.ch  = ch;
        e.due = edge_cnt + 4;
        base = ld ? cv : acc_s[ch];
        sum  = op[2] ? base - prod : base + prod;
        e.ovf_s = (sum > MAXV) || (sum < MINV);
        nv = clamp48(sum);
        acc_s[ch] = nv;
        if (e.ovf_s) stk_s[ch] = 1'b1;
        e.p_s = nv;
        base = ld ? cv : acc_w[ch];
        sum  = op[2] ? base - prod : base + prod;
        e.ovf_w = (sum > MAXV) || (sum < MINV);
        nv = wrap48(sum);
        acc_w[ch] = nv;
        if (e.ovf_w) stk_w[ch] = 1'b1;
        e.p_w = nv;
        base = cv;
        if (!ld) begin
            base = 0;
            if (ch < 3) base = acc_r[ch];
        end
        sum  = op[2] ? base - prod : base + prod;
        e.ovf_r = (sum > MAXV) || (sum < MINV);
        nv = clamp48(sum);
        if (ch < 3) begin
            acc_r[ch] = nv;
            if (e.ovf_r) stk_r[ch] = 1'b1;
        end
        e.p_r = clamp48((nv + 2) >>> 2);
        sb.push_back(e);
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        chk("drain_pending", sb.size(), 0);
    endtask

    task automatic chk_sticky(input string tag);
        chk({tag, "_s"}, s_stk, stk_s);
        chk({tag, "_w"}, w_stk, stk_w);
        chk({tag, "_r"}, r_stk, stk_r);
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", s_valid, 0);
        chk("rst_p", $signed(s_p), 0);
        chk("rst_ch", s_ch, 0);
        chk("rst_ovf", s_ovf, 0);
        chk_sticky("rst_sticky");

        // basic latency: 3*4 + 10 = 22
        send(0, 1, 3'b000, 3, 4, 0, 10);
        drain();
        idle(2);
        chk("hold_p", $signed(s_p), 22);
        chk("hold_valid", s_valid, 0);

        // pre-adder subtract then pre-add with post-subtract: -12, then -22
        send(1, 1, 3'b011, -2, 4, 10, 0);
        send(1, 0, 3'b101, 5, 1, 1, 0);
        drain();
        chk("postsub_p", $signed(s_p), -22);

        // interleaved channels back to back
        send(0, 1, 3'b000, 1, 1, 0, 0);
        send(1, 1, 3'b000, 1, 1, 0, 0);
        send(0, 0, 3'b000, 1, 1, 0, 0);
        send(1, 0, 3'b000, 1, 1, 0, 0);
        drain();

        // saturation versus wrap
        send(2, 1, 3'b000, 0, 0, 0, MAXV);
        send(2, 0, 3'b000, 1, 1, 0, 0);
        drain();
        chk("sat_p", $signed(s_p), MAXV);
        chk("wrap_p", $signed(w_p), MINV);
        chk_sticky("sat_sticky");
        chk("sat_sticky_bit", s_stk[2], 1);

        // standalone clear
        clr_acc = 1'b1;
        step();
        clr_acc = 1'b0;
        model_clear();
        chk_sticky("clr_sticky");
        send(2, 0, 3'b000, 0, 0, 0, 0);
        drain();

        // clear coincident with an overflowing write: result still emitted, bank zeroed
        send(0, 1, 3'b000, 1, 1, 0, MAXV);
        in_valid = 1'b0;
        step();
        clr_acc = 1'b1;
        step();
        clr_acc = 1'b0;
        model_clear();
        drain();
        chk_sticky("clr_win_sticky");
        send(0, 0, 3'b000, 0, 0, 0, 0);
        drain();

        // stall mid-flight and output rounding (6 -> 2, -6 -> -1)
        send(3, 1, 3'b000, 0, 0, 0, 6);
        in_valid = 1'b0;
        step();
        en = 1'b0;
        step();
        step();
        en = 1'b1;
        drain();
        chk("round_pos", $signed(r_p), 2);
        send(1, 1, 3'b000, 0, 0, 0, -6);
        drain();
        chk("round_neg", $signed(r_p), -1);

        // channel beyond the scaled instance's bank: base 0 and no write
        send(3, 0, 3'b000, 1, 1, 0, 0);
        drain();
        chk("oob_r", $signed(r_p), 0);

        // asynchronous reset with samples in flight
        send(2, 1, 3'b000, 1, 1, 0, MAXV);
        send(0, 1, 3'b000, 1, 1, 0, 7);
        send(1, 1, 3'b000, 1, 2, 0, 0);
        send(0, 0, 3'b000, 1, 1, 0, 0);
        in_valid = 1'b0;
        chk("pre_rst_sticky", s_stk[2], 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid_s", s_valid, 0);
        chk("arst_valid_w", w_valid, 0);
        chk("arst_valid_r", r_valid, 0);
        chk("arst_p", $signed(s_p), 0);
        sb.delete();
        model_clear();
        chk_sticky("arst_sticky");
        @(posedge clk);
        #3 rst = 1'b0;
        idle(6);
        send(0, 0, 3'b000, 0, 0, 0, 0);
        send(1, 0, 3'b000, 0, 0, 0, 0);
        send(2, 0, 3'b000, 0, 0, 0, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
